// File: rtl/button_debounce_multi.sv
// N-channel push-button filter: 2-FF synchroniser, per-channel debounce, level plus press/release pulses.
// Define BUTTON_AUTOREPEAT_EN to add periodic oPress repeats while a channel is held.
module button_debounce_multi #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 25000,
    parameter int REPEAT_PERIOD   = 5000
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [N_BTN-1:0] iBTN,
    output logic [N_BTN-1:0] oState,
    output logic [N_BTN-1:0] oPress,
    output logic [N_BTN-1:0] oRelease,
    output logic             oAny
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (N_BTN < 1 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W) ||
        longint'(REPEAT_DELAY) > (longint'(1) << CNT_W) ||
        longint'(REPEAT_PERIOD) > (longint'(1) << CNT_W)) begin : g_param_check
        $error("button_debounce_multi: illegal parameter combination");
    end

    logic [N_BTN-1:0]            sync_p0;
    logic [N_BTN-1:0]            sync_p1;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_q;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_nxt;
    logic [N_BTN-1:0]            state_nxt;
    logic [N_BTN-1:0]            press_nxt;
    logic [N_BTN-1:0]            release_nxt;
    logic [N_BTN-1:0]            accept;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [N_BTN-1:0][CNT_W-1:0] rcnt_q;
    logic [N_BTN-1:0][CNT_W-1:0] rcnt_nxt;
    logic [N_BTN-1:0]            rep_q;
    logic [N_BTN-1:0]            rep_nxt;
`endif

    // Stage p1 -> outputs: debounce decision per channel
    always_comb begin
        state_nxt   = oState;
        press_nxt   = '0;
        release_nxt = '0;
        accept      = '0;
        cnt_nxt     = '0;
`ifdef BUTTON_AUTOREPEAT_EN
        rcnt_nxt    = '0;
        rep_nxt     = '0;
`endif
        for (int i = 0; i < N_BTN; i++) begin
            if (sync_p1[i] != oState[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    accept[i]      = 1'b1;
                    state_nxt[i]   = sync_p1[i];
                    press_nxt[i]   = sync_p1[i];
                    release_nxt[i] = ~sync_p1[i];
                end else begin
                    cnt_nxt[i] = cnt_q[i] + CNT_ONE;
                end
            end
`ifdef BUTTON_AUTOREPEAT_EN
            // Repeat timer runs only while held; the release edge must not also emit a press
            if (oState[i] && !accept[i]) begin
                if (rcnt_q[i] == (rep_q[i] ? RP_LAST : RD_LAST)) begin
                    press_nxt[i] = 1'b1;
                    rep_nxt[i]   = 1'b1;
                end else begin
                    rcnt_nxt[i] = rcnt_q[i] + CNT_ONE;
                    rep_nxt[i]  = rep_q[i];
                end
            end
`endif
        end
    end

    // Stage iBTN -> p0 -> p1 synchroniser, then registered outputs
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            cnt_q    <= '0;
            oState   <= '0;
            oPress   <= '0;
            oRelease <= '0;
            oAny     <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            rcnt_q   <= '0;
            rep_q    <= '0;
`endif
        end else begin
            sync_p0  <= iBTN;
            sync_p1  <= sync_p0;
            cnt_q    <= cnt_nxt;
            oState   <= state_nxt;
            oPress   <= press_nxt;
            oRelease <= release_nxt;
            oAny     <= |state_nxt;
`ifdef BUTTON_AUTOREPEAT_EN
            rcnt_q   <= rcnt_nxt;
            rep_q    <= rep_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Scoreboard bench for button_debounce_multi (N_BTN=5, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
module tb_button_debounce_multi;

    localparam int N = 5;

    typedef struct {
        int           at;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
        logic [N-1:0] st;
    } ev_t;

    logic         CLK   = 1'b0;
    logic         Reset = 1'b1;
    logic [N-1:0] btn   = '0;
    logic [N-1:0] oState;
    logic [N-1:0] oPress;
    logic [N-1:0] oRelease;
    logic         oAny;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t q[$];
    ev_t mon_e;

    button_debounce_multi #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(8),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .iBTN(btn),
        .oState(oState),
        .oPress(oPress),
        .oRelease(oRelease),
        .oAny(oAny)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive(input logic [N-1:0] v);
        @(negedge CLK);
        btn = v;
    endtask

    task automatic expect_ev(input int at, input logic [N-1:0] pr, input logic [N-1:0] rl,
                             input logic [N-1:0] st);
        ev_t e;
        e.at = at;
        e.pr = pr;
        e.rl = rl;
        e.st = st;
        q.push_back(e);
    endtask

    // Monitor: every pulse cycle must match the head of the scoreboard
    always @(negedge CLK) begin
        if (!Reset && ((oPress | oRelease) != '0)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: cycle %0d press %b release %b, expected no pulse",
                         cyc, oPress, oRelease);
            end else begin
                mon_e = q.pop_front();
                chk("ev_cycle", cyc, mon_e.at);
                chk("ev_press", 32'(oPress), 32'(mon_e.pr));
                chk("ev_release", 32'(oRelease), 32'(mon_e.rl));
                chk("ev_state", 32'(oState), 32'(mon_e.st));
                chk("ev_any", 32'(oAny), 32'(|mon_e.st));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int a;

        // Reset state
        tick(3);
        chk("rst_state", 32'(oState), 0);
        chk("rst_press", 32'(oPress), 0);
        chk("rst_release", 32'(oRelease), 0);
        chk("rst_any", 32'(oAny), 0);
        @(negedge CLK);
        Reset = 1'b0;
        tick(3);

        // Scenario 1: all channels pressed, then asynchronous reset while held
        drive(5'b11111);
        p = cyc;
        expect_ev(p + 6, 5'b11111, 5'b00000, 5'b11111);
        tick(5);
        chk("s1_not_yet", 32'(oState), 0);
        tick(8);
        chk("s1_held", 32'(oState), 32'h1f);
        @(posedge CLK);
        #2 Reset = 1'b1;
        #1;
        chk("s1_async_state", 32'(oState), 0);
        chk("s1_async_press", 32'(oPress), 0);
        chk("s1_async_release", 32'(oRelease), 0);
        chk("s1_async_any", 32'(oAny), 0);
        tick(3);
        @(negedge CLK);
        Reset = 1'b0;
        p = cyc;
        expect_ev(p + 6, 5'b11111, 5'b00000, 5'b11111);
        tick(5);
        chk("s1_redebounce", 32'(oState), 0);
        tick(8);
        drive(5'b00000);
        p = cyc;
        expect_ev(p + 6, 5'b00000, 5'b11111, 5'b00000);
        tick(12);

        // Scenario 2: bouncing channel 0 then settling high
        for (int i = 0; i < 10; i++) begin
            drive(5'b00001);
            tick(1);
            drive(5'b00000);
            tick(1);
        end
        chk("s2_bounce_state", 32'(oState), 0);
        drive(5'b00001);
        p = cyc;
        expect_ev(p + 6, 5'b00001, 5'b00000, 5'b00001);
        tick(12);
        drive(5'b00000);
        p = cyc;
        expect_ev(p + 6, 5'b00000, 5'b00001, 5'b00000);
        tick(12);

        // Scenario 3: short and long drops on channel 2
        drive(5'b00100);
        p = cyc;
        expect_ev(p + 6, 5'b00100, 5'b00000, 5'b00100);
        tick(12);
        drive(5'b00000);
        tick(1);
        drive(5'b00100);
        tick(12);
        chk("s3_glitch_ignored", 32'(oState), 32'h04);
        drive(5'b00000);
        p = cyc;
        expect_ev(p + 6, 5'b00000, 5'b00100, 5'b00000);
        tick(5);
        drive(5'b00100);
        p = cyc;
        expect_ev(p + 6, 5'b00100, 5'b00000, 5'b00100);
        tick(12);
        drive(5'b00000);
        p = cyc;
        expect_ev(p + 6, 5'b00000, 5'b00100, 5'b00000);
        tick(12);

        // Scenario 4: simultaneous channels 1 and 4
        drive(5'b10010);
        p = cyc;
        expect_ev(p + 6, 5'b10010, 5'b00000, 5'b10010);
        tick(12);
        drive(5'b00000);
        p = cyc;
        expect_ev(p + 6, 5'b00000, 5'b10010, 5'b00000);
        tick(12);

        // Scenario 5/6: channel 3 held 30 cycles
        drive(5'b01000);
        p = cyc;
        a = p + 6;
        expect_ev(a, 5'b01000, 5'b00000, 5'b01000);
`ifdef BUTTON_AUTOREPEAT_EN
        for (int t = a + 10; t < a + 30; t += 3)
            expect_ev(t, 5'b01000, 5'b00000, 5'b01000);
`endif
        tick(29);
        drive(5'b00000);
        expect_ev(a + 30, 5'b00000, 5'b01000, 5'b00000);
        tick(15);

        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
